uart_code: RTL and testbench
============================

// Module: uart_code
// PURPOSE
// - 32-bit-word UART with an internal loopback: a transmitter serialises a 32-bit word onto tx_serial.
// - A receiver, fed internally from tx_serial, deserialises it back to rx_byte.
// - Used as a self-checking serial-link block and the reference TX/RX pair for wider-frame UART links.
// PARAMETERS
// - CLKS_PER_BIT  86  clock cycles per serial bit (iclk / baud); legal range >= 4.
// PORTS
// - iclk           in   1   sole clock, all logic on posedge
// - irst_n         in   1   reset; synchronous, active-low
// - tx_data_valid  in   1   request: start a frame with tx_byte; sampled only in TX IDLE
// - tx_byte        in   32  word to send; captured on the accepted request cycle
// - tx_active      out  1   high while a TX frame (start..stop) is on the line
// - tx_serial      out  1   serial line; idles high
// - tx_done        out  1   one-cycle pulse after the stop bit completes
// - rx_data_valid  out  1   one-cycle pulse: rx_byte holds a newly received word
// - rx_byte        out  32  last received word; held until the next good frame
// BEHAVIOUR
// - Reset (irst_n=0 at posedge): both FSMs go to IDLE; counters = 0.
//   - Outputs after reset: tx_serial=1, tx_active=0, tx_done=0, rx_data_valid=0, rx_byte=0.
//   - Reset mid-frame aborts the frame; no done or valid pulse follows.
// - Frame: 1 start bit (0), 32 data bits LSB first, 1 stop bit (1).
//   - Each bit lasts exactly CLKS_PER_BIT cycles; total 34*CLKS_PER_BIT cycles.
// - TX FSM states: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
//   - IDLE: tx_serial=1. If tx_data_valid=1, latch tx_byte and go to START; tx_active=1 from that edge.
//   - START: drive 0 for CLKS_PER_BIT cycles.
//   - DATA: drive bit[i], i = 0..31, for CLKS_PER_BIT cycles each; 5-bit index.
//   - STOP: drive 1 for CLKS_PER_BIT cycles.
//   - CLEANUP: exactly 1 cycle; tx_done=1, tx_active=0, tx_serial=1.
// - tx_data_valid is ignored outside IDLE, including the CLEANUP cycle. tx_byte changes during a frame do not affect it.
// - Back-to-back: a request asserted in the cycle after tx_done is accepted normally.
// - RX path: tx_serial passes through a 2-flop synchroniser (reset value 1) before the RX FSM.
// - RX FSM states: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
//   - IDLE: a synchronised 0 moves the FSM to START.
//   - START: wait (CLKS_PER_BIT-1)/2 cycles (mid-bit) and re-sample.
//     - Still 0: go to DATA.
//     - 1: false start; return to IDLE with no pulse.
//   - DATA: sample every CLKS_PER_BIT cycles at mid-bit; shift into bit[i], LSB first.
//   - STOP: sample at mid-bit.
//     - 1: load rx_byte and pulse rx_data_valid for 1 cycle.
//     - 0: framing error; discard the word, rx_byte unchanged, no pulse.
//   - CLEANUP: 1 cycle, then IDLE.
// - Ordering: for a loopback frame, rx_data_valid pulses before that frame's tx_done.
// - Counters are sized $clog2(CLKS_PER_BIT) bits and wrap to 0 at CLKS_PER_BIT-1. There is no other arithmetic.
// CONFIGURATION
// - UART_PARITY_EN defined:
//   - An even-parity bit (XOR of the 32 data bits) is inserted between DATA and STOP; the frame is 35 bits.
//   - Added output port rx_parity_err (1 bit, reset 0) pulses 1 cycle on mismatch.
//   - On mismatch the word is discarded: no rx_data_valid, rx_byte unchanged.
// - UART_PARITY_EN undefined: 34-bit frame as above; no parity logic and no rx_parity_err port.
// TESTING
// - Reset: hold irst_n=0 for 3 cycles -> tx_serial=1, tx_active=0, tx_done=0, rx_data_valid=0, rx_byte=0.
// - Send 32'h0F3CC3F0, valid for 1 cycle. Required response:
//   - tx_active high for 34*86 cycles; tx_done pulses once.
//   - rx_data_valid pulses once, before tx_done; rx_byte=32'h0F3CC3F0.
// - After tx_done, send 32'hFFFFFFFF -> line stays low exactly 86 cycles (start only); rx_byte=32'hFFFFFFFF.
// - Pulse tx_data_valid repeatedly mid-frame with tx_byte=32'h12345678. Required response:
//   - The frame in flight is unchanged.
//   - No extra frame starts; exactly one tx_done.
// - Assert irst_n=0 at bit 10 of a frame -> tx_serial=1 next cycle; no tx_done and no rx_data_valid. The next frame, 32'hA5A5A5A5, is received correctly.
// - Bit timing: sample tx_serial for 32'h00000001 -> start low 86 cycles, bit0 high 86 cycles, bits1..31 low 31*86 cycles, stop high.

Source files
------------

// File: rtl/uart_code.sv
// uart_code: 32-bit-word UART transmitter and receiver joined by an internal
// loopback (receiver listens to tx_serial through a 2-flop synchroniser).
// Frame: start(0), 32 data bits LSB first, stop(1); each bit CLKS_PER_BIT clocks.
// Optional build macro UART_PARITY_EN inserts an even-parity bit before the
// stop bit and adds the rx_parity_err output.
module uart_code #(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        tx_data_valid,
    input  logic [31:0] tx_byte,
    output logic        tx_active,
    output logic        tx_serial,
    output logic        tx_done,
    output logic        rx_data_valid,
    output logic [31:0] rx_byte
`ifdef UART_PARITY_EN
    ,
    output logic        rx_parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP,
        TX_CLEANUP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t      r_tx_state, w_tx_state_next;
    logic [CW-1:0]  r_tx_cnt,   w_tx_cnt_next;
    logic [4:0]     r_tx_idx,   w_tx_idx_next;
    logic [31:0]    r_tx_data,  w_tx_data_next;
    logic           w_tx_cnt_last;

    assign w_tx_cnt_last = (r_tx_cnt == LAST_CNT);

    // TX state register: word latch, bit counter and bit index
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_data  <= '0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_idx   <= w_tx_idx_next;
            r_tx_data  <= w_tx_data_next;
        end
    end

    // TX next-state and line/status outputs decoded from the current state
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt;
        w_tx_idx_next   = r_tx_idx;
        w_tx_data_next  = r_tx_data;
        tx_serial       = 1'b1;
        tx_active       = 1'b0;
        tx_done         = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_next = '0;
                w_tx_idx_next = '0;
                if (tx_data_valid) begin
                    w_tx_data_next  = tx_byte;
                    w_tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_serial = 1'b0;
                tx_active = 1'b1;
                if (w_tx_cnt_last) begin
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = TX_DATA;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                tx_serial = r_tx_data[r_tx_idx];
                tx_active = 1'b1;
                if (w_tx_cnt_last) begin
                    w_tx_cnt_next = '0;
                    if (r_tx_idx == 5'd31) begin
`ifdef UART_PARITY_EN
                        w_tx_state_next = TX_PARITY;
`else
                        w_tx_state_next = TX_STOP;
`endif
                    end else begin
                        w_tx_idx_next = r_tx_idx + 5'd1;
                    end
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                // even parity: line carries the XOR of all data bits
                tx_serial = ^r_tx_data;
                tx_active = 1'b1;
                if (w_tx_cnt_last) begin
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = TX_STOP;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                tx_active = 1'b1;
                if (w_tx_cnt_last) begin
                    w_tx_cnt_next   = '0;
                    w_tx_state_next = TX_CLEANUP;
                end else begin
                    w_tx_cnt_next = r_tx_cnt + 1'b1;
                end
            end
            TX_CLEANUP: begin
                // requests are deliberately ignored here; next accept is from IDLE
                tx_done         = 1'b1;
                w_tx_state_next = TX_IDLE;
            end
            default: begin
                w_tx_state_next = TX_IDLE;
            end
        endcase
    end

    // ---------------- receiver ----------------
    logic [1:0]     r_rx_sync;
    logic           w_rx_in;
    rx_state_t      r_rx_state, w_rx_state_next;
    logic [CW-1:0]  r_rx_cnt,   w_rx_cnt_next;
    logic [4:0]     r_rx_idx,   w_rx_idx_next;
    logic [31:0]    r_rx_shift, w_rx_shift_next;
    logic [31:0]    r_rx_byte,  w_rx_byte_next;
    logic           r_rx_valid, w_rx_valid_next;
`ifdef UART_PARITY_EN
    logic           r_rx_par_bad, w_rx_par_bad_next;
    logic           r_rx_parity_err, w_rx_parity_err_next;
`endif

    assign w_rx_in       = r_rx_sync[1];
    assign rx_byte       = r_rx_byte;
    assign rx_data_valid = r_rx_valid;
`ifdef UART_PARITY_EN
    assign rx_parity_err = r_rx_parity_err;
`endif

    // Loopback synchroniser; resets to the idle (high) line level
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], tx_serial};
        end
    end

    // RX state register: sampling counter, shift register and output word
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_rx_state      <= RX_IDLE;
            r_rx_cnt        <= '0;
            r_rx_idx        <= '0;
            r_rx_shift      <= '0;
            r_rx_byte       <= '0;
            r_rx_valid      <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad    <= 1'b0;
            r_rx_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_state      <= w_rx_state_next;
            r_rx_cnt        <= w_rx_cnt_next;
            r_rx_idx        <= w_rx_idx_next;
            r_rx_shift      <= w_rx_shift_next;
            r_rx_byte       <= w_rx_byte_next;
            r_rx_valid      <= w_rx_valid_next;
`ifdef UART_PARITY_EN
            r_rx_par_bad    <= w_rx_par_bad_next;
            r_rx_parity_err <= w_rx_parity_err_next;
`endif
        end
    end

    // RX next-state: find start edge, re-check at mid-bit, then sample each bit centre
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_cnt_next   = r_rx_cnt;
        w_rx_idx_next   = r_rx_idx;
        w_rx_shift_next = r_rx_shift;
        w_rx_byte_next  = r_rx_byte;
        w_rx_valid_next = 1'b0;
`ifdef UART_PARITY_EN
        w_rx_par_bad_next    = r_rx_par_bad;
        w_rx_parity_err_next = 1'b0;
`endif
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_next = '0;
                w_rx_idx_next = '0;
`ifdef UART_PARITY_EN
                w_rx_par_bad_next = 1'b0;
`endif
                if (!w_rx_in) begin
                    w_rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == MID_CNT) begin
                    w_rx_cnt_next = '0;
                    // a line that went high again was a glitch, not a start bit
                    w_rx_state_next = w_rx_in ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_next   = '0;
                    w_rx_shift_next = {w_rx_in, r_rx_shift[31:1]};
                    if (r_rx_idx == 5'd31) begin
`ifdef UART_PARITY_EN
                        w_rx_state_next = RX_PARITY;
`else
                        w_rx_state_next = RX_STOP;
`endif
                    end else begin
                        w_rx_idx_next = r_rx_idx + 5'd1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_next        = '0;
                    w_rx_par_bad_next    = (w_rx_in != ^r_rx_shift);
                    w_rx_parity_err_next = (w_rx_in != ^r_rx_shift);
                    w_rx_state_next      = RX_STOP;
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (r_rx_cnt == LAST_CNT) begin
                    w_rx_cnt_next   = '0;
                    w_rx_state_next = RX_CLEANUP;
`ifdef UART_PARITY_EN
                    if (w_rx_in && !r_rx_par_bad) begin
`else
                    if (w_rx_in) begin
`endif
                        w_rx_byte_next  = r_rx_shift;
                        w_rx_valid_next = 1'b1;
                    end
                end else begin
                    w_rx_cnt_next = r_rx_cnt + 1'b1;
                end
            end
            RX_CLEANUP: begin
                w_rx_state_next = RX_IDLE;
            end
            default: begin
                w_rx_state_next = RX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_code.sv
// tb_uart_code: randomized loopback test of uart_code against a frame-position
// model (expected line level = function of cycles since the accepted request).
module tb_uart_code;

    localparam int N = 86;
`ifdef UART_PARITY_EN
    localparam int NB = 35;
`else
    localparam int NB = 34;
`endif
    localparam int FRAME = NB * N;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        tx_data_valid = 1'b0;
    logic [31:0] tx_byte = '0;
    logic        tx_active, tx_serial, tx_done, rx_data_valid;
    logic [31:0] rx_byte;
`ifdef UART_PARITY_EN
    logic        rx_parity_err;
`endif

    uart_code #(.CLKS_PER_BIT(N)) dut (
        .iclk          (iclk),
        .irst_n        (irst_n),
        .tx_data_valid (tx_data_valid),
        .tx_byte       (tx_byte),
        .tx_active     (tx_active),
        .tx_serial     (tx_serial),
        .tx_done       (tx_done),
        .rx_data_valid (rx_data_valid),
        .rx_byte       (rx_byte)
`ifdef UART_PARITY_EN
        ,
        .rx_parity_err (rx_parity_err)
`endif
    );

    always #5 iclk = ~iclk;

    int          total = 0;
    int          bad = 0;
    // model: position in frame since accepting edge (-1 = idle)
    int          m_pos = -1;
    logic [31:0] m_word = '0;
    logic [31:0] m_rx = '0;
    bit          m_seen = 0;
    bit          chk_en = 0;
    // per-frame observations
    int          runs[$];
    logic        cur_val = 1'b1;
    int          cur_len = 0;
    int          f_active = 0, f_done = 0, f_rxv = 0, f_rxv_late = 0;
    bit          prev_active = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, plus frame statistics
    task automatic compare();
        logic exp_serial, exp_active, exp_done;
        int   bitn;
        exp_serial = 1'b1;
        exp_active = 1'b0;
        exp_done   = 1'b0;
        if (m_pos >= 0 && m_pos < FRAME) begin
            exp_active = 1'b1;
            bitn = m_pos / N;
            if (bitn == 0) exp_serial = 1'b0;
            else if (bitn <= 32) exp_serial = m_word[bitn-1];
`ifdef UART_PARITY_EN
            else if (bitn == 33) exp_serial = ^m_word;
`endif
        end else if (m_pos == FRAME) begin
            exp_done = 1'b1;
        end
        check("tx_serial", tx_serial, exp_serial);
        check("tx_active", tx_active, exp_active);
        check("tx_done", tx_done, exp_done);
`ifdef UART_PARITY_EN
        check("rx_parity_err", rx_parity_err, 1'b0);
`endif
        if (rx_data_valid) begin
            check("rx_valid_in_frame", (m_pos >= 0 && m_pos < FRAME && !m_seen), 1'b1);
            check("rx_byte_new", rx_byte, m_word);
            m_seen = 1;
            m_rx   = m_word;
        end else begin
            check("rx_byte_hold", rx_byte, m_rx);
        end
        if (m_pos == FRAME) check("rx_valid_before_done", m_seen, 1'b1);

        if (tx_active && !prev_active) begin
            runs.delete();
            cur_len = 0; f_active = 0; f_done = 0; f_rxv = 0; f_rxv_late = 0;
        end
        if (tx_active) begin
            f_active++;
            if (cur_len > 0 && tx_serial == cur_val) cur_len++;
            else begin
                if (cur_len > 0) runs.push_back(cur_len);
                cur_val = tx_serial;
                cur_len = 1;
            end
        end
        if (tx_done) begin
            f_done++;
            if (cur_len > 0) runs.push_back(cur_len);
            cur_len = 0;
        end
        if (rx_data_valid) begin
            if (f_done == 0) f_rxv++;
            else f_rxv_late++;
        end
        prev_active = tx_active;
    endtask

    // One clock: model absorbs inputs seen at the edge, new inputs applied, outputs checked
    task automatic cycle(input logic v, input logic [31:0] b, input logic r);
        @(posedge iclk);
        if (!irst_n) begin
            m_pos = -1; m_rx = '0; m_seen = 0; chk_en = 1;
        end else if (m_pos < 0) begin
            if (tx_data_valid) begin
                m_pos = 0; m_word = tx_byte; m_seen = 0;
            end
        end else if (m_pos >= FRAME) begin
            m_pos = -1;
        end else begin
            m_pos++;
        end
        #1;
        tx_data_valid = v;
        tx_byte       = b;
        irst_n        = r;
        @(negedge iclk);
        if (chk_en) compare();
    endtask

    // Request one frame and run until its tx_done (bounded)
    task automatic send(input logic [31:0] w, input bit noisy);
        bit got;
        int n;
        logic v;
        got = 0;
        n = 0;
        cycle(1'b1, w, 1'b1);
        while (n < FRAME + 20 && !got) begin
            v = noisy && (($urandom_range(0, 5) == 0) || (m_pos == FRAME - 1));
            cycle(v, noisy ? 32'h12345678 : $urandom, 1'b1);
            n++;
            got = (tx_done === 1'b1);
        end
        check("frame_completes", got, 1'b1);
        if (noisy) cycle(1'b0, $urandom, 1'b1);
        $display("frame word=%08h noisy=%0d rx_byte=%08h active=%0d done=%0d", w, noisy, rx_byte, f_active, f_done);
    endtask

    initial begin
        logic [31:0] w;
        // reset held over three edges
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("rst_tx_serial", tx_serial, 1'b1);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        check("rst_rx_valid", rx_data_valid, 1'b0);
        check("rst_rx_byte", rx_byte, 32'h0);

        // directed word
        send(32'h0F3CC3F0, 1'b0);
`ifdef UART_PARITY_EN
        check("w1_active_cycles", f_active, 3010);
`else
        check("w1_active_cycles", f_active, 2924);
`endif
        check("w1_done_count", f_done, 1);
        check("w1_rx_pulses", f_rxv, 1);
        check("w1_rx_late", f_rxv_late, 0);
        check("w1_rx_byte", rx_byte, 32'h0F3CC3F0);

        // back-to-back all-ones: only the start bit is low
        send(32'hFFFFFFFF, 1'b0);
        check("ones_start_low", runs[0], 86);
        check("ones_rx_byte", rx_byte, 32'hFFFFFFFF);
`ifdef UART_PARITY_EN
        check("ones_runs", runs.size(), 4);
`else
        check("ones_runs", runs.size(), 2);
        check("ones_high_run", runs[1], 2838);
`endif

        // bit timing of a single set LSB
        send(32'h00000001, 1'b0);
        check("one_start", runs[0], 86);
        check("one_bit0", runs[1], 86);
        check("one_bits1_31", runs[2], 2666);
`ifdef UART_PARITY_EN
        check("one_par_stop", runs[3], 172);
`else
        check("one_stop", runs[3], 86);
`endif
        check("one_rx_byte", rx_byte, 32'h00000001);

        // requests during a frame (including the cleanup cycle) are ignored
        w = $urandom;
        send(w, 1'b1);
        check("noisy_done_count", f_done, 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, $urandom, 1'b1);
        check("noisy_no_new_frame", tx_active, 1'b0);
        check("noisy_rx_byte", rx_byte, w);

        // reset during data bit 10 aborts the frame
        cycle(1'b1, $urandom, 1'b1);
        for (int i = 0; i < 11 * N + 5; i++) cycle(1'b0, $urandom, 1'b1);
        cycle(1'b0, $urandom, 1'b0);
        cycle(1'b0, $urandom, 1'b1);
        check("abort_serial_high", tx_serial, 1'b1);
        for (int i = 0; i < 200; i++) cycle(1'b0, $urandom, 1'b1);
        check("abort_no_done", f_done, 0);
        check("abort_no_rx", f_rxv, 0);
        send(32'hA5A5A5A5, 1'b0);
        check("after_abort_rx_byte", rx_byte, 32'hA5A5A5A5);

        // randomized frames with random gaps and random mid-frame requests
        for (int k = 0; k < 6; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++) cycle(1'b0, $urandom, 1'b1);
            w = $urandom;
            send(w, $urandom_range(0, 1) == 1);
            check("rand_rx_byte", rx_byte, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
